// File: rtl/uart_debug_parser.sv
`default_nettype none
// ============================================================================
// Module   : uart_debug_parser
// Brief    : 8N1 UART receiver feeding an ASCII "R|W <addr> <data>" command
//            parser that issues one-cycle write strobes into a downstream fifo.
//            Optional echo transmitter enabled by UART_DEBUG_PARSER_ECHO_EN.
// Revision : 1.0 - initial release
// ============================================================================

`ifdef UART_DEBUG_PARSER_ECHO_EN
module uart_tx #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       anrst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txd,
  output logic       busy
);
  localparam int c_cw = $clog2(DIV);
  localparam logic [c_cw-1:0] c_cnt_last = c_cw'(DIV - 1);

  logic [8:0]      r_shift;
  logic [c_cw-1:0] r_cnt;
  logic [3:0]      r_bits;

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      txd     <= 1'b1;
      busy    <= 1'b0;
      r_shift <= '1;
      r_cnt   <= '0;
      r_bits  <= '0;
    end else if (!busy) begin
      if (start) begin
        busy    <= 1'b1;
        txd     <= 1'b0;
        r_shift <= {1'b1, data};
        r_cnt   <= '0;
        r_bits  <= '0;
      end
    end else if (r_cnt == c_cnt_last) begin
      r_cnt <= '0;
      // r_bits==9 means the stop bit has been on the line for a full period
      if (r_bits == 4'd9) begin
        busy <= 1'b0;
        txd  <= 1'b1;
      end else begin
        txd     <= r_shift[0];
        r_shift <= {1'b1, r_shift[8:1]};
        r_bits  <= r_bits + 4'd1;
      end
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule
`endif

module uart_debug_parser #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200
) (
  input  logic        clk,
  input  logic        anrst,
  input  logic        uart_rxd,
  output logic        uart_txd,
  input  logic        full,
  output logic        w_req,
  output logic        w_rnw,
  output logic [31:0] w_addr,
  output logic [31:0] w_data,
  output logic        err
);
  localparam int c_div  = CLK_HZ / BAUD;
  localparam int c_half = c_div / 2;
  localparam int c_cw   = $clog2(c_div);
  localparam logic [c_cw-1:0] c_cnt_last = c_cw'(c_div - 1);
  localparam logic [c_cw-1:0] c_cnt_half = c_cw'(c_half - 1);
  localparam logic [7:0] c_cr = 8'h0D;
  localparam logic [7:0] c_lf = 8'h0A;
  localparam logic [7:0] c_sp = 8'h20;
  localparam logic [7:0] c_us = 8'h5F;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {
    P_IDLE, P_SEP1, P_ADDR, P_SEP2, P_DATA, P_WAIT_CR, P_DISCARD
  } p_state_t;

  logic            r_sync1;
  logic            r_sync2;
  logic            r_rx_prev;
  rx_state_t       r_rx_state;
  logic [c_cw-1:0] r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_rx_byte;
  logic            r_byte_valid;
  logic            r_frame_err;

  p_state_t        r_p_state;
  logic [2:0]      r_digits;

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_rx_prev    <= 1'b1;
      r_rx_state   <= RX_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_rx_byte    <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_sync1      <= uart_rxd;
      r_sync2      <= r_sync1;
      r_rx_prev    <= r_sync2;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_prev && !r_sync2) begin
            r_rx_state <= RX_START;
            r_cnt      <= '0;
          end
        end
        RX_START: begin
          if (r_cnt == c_cnt_half) begin
            r_cnt <= '0;
            // a start bit that is high again at mid-point was a glitch
            if (r_sync2) begin
              r_rx_state <= RX_IDLE;
            end else begin
              r_rx_state <= RX_DATA;
              r_bit      <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == c_cnt_last) begin
            r_cnt     <= '0;
            r_rx_byte <= {r_sync2, r_rx_byte[7:1]};
            r_bit     <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
              r_rx_state <= RX_STOP;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_cnt == c_cnt_last) begin
            r_cnt      <= '0;
            r_rx_state <= RX_IDLE;
            if (r_sync2) begin
              r_byte_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  logic       w_is_hex;
  logic [3:0] w_nibble;
  logic       w_is_r;
  logic       w_is_w;

  // ASCII digits carry their value in the low nibble; A-F/a-f are offset by 9
  always_comb begin
    w_is_hex = 1'b1;
    w_nibble = 4'd0;
    if (r_rx_byte >= 8'h30 && r_rx_byte <= 8'h39) begin
      w_nibble = r_rx_byte[3:0];
    end else if ((r_rx_byte >= 8'h41 && r_rx_byte <= 8'h46) ||
                 (r_rx_byte >= 8'h61 && r_rx_byte <= 8'h66)) begin
      w_nibble = r_rx_byte[3:0] + 4'd9;
    end else begin
      w_is_hex = 1'b0;
    end
  end

  assign w_is_r = (r_rx_byte == 8'h52) || (r_rx_byte == 8'h72);
  assign w_is_w = (r_rx_byte == 8'h57) || (r_rx_byte == 8'h77);

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      r_p_state <= P_IDLE;
      r_digits  <= '0;
      w_req     <= 1'b0;
      err       <= 1'b0;
      w_rnw     <= 1'b0;
      w_addr    <= '0;
      w_data    <= '0;
    end else begin
      w_req <= 1'b0;
      err   <= 1'b0;
      if (r_frame_err) begin
        err       <= 1'b1;
        r_p_state <= P_DISCARD;
      end else if (r_byte_valid) begin
        case (r_p_state)
          P_IDLE: begin
            if (w_is_r) begin
              w_rnw     <= 1'b1;
              r_p_state <= P_SEP1;
            end else if (w_is_w) begin
              w_rnw     <= 1'b0;
              r_p_state <= P_SEP1;
            end else if (r_rx_byte != c_cr && r_rx_byte != c_lf && r_rx_byte != c_sp) begin
              err       <= 1'b1;
              r_p_state <= P_DISCARD;
            end
          end
          P_SEP1, P_SEP2: begin
            if (r_rx_byte == c_sp) begin
              r_digits <= '0;
              if (r_p_state == P_SEP1) begin
                r_p_state <= P_ADDR;
              end else begin
                r_p_state <= P_DATA;
              end
            end else begin
              err       <= 1'b1;
              r_p_state <= P_DISCARD;
            end
          end
          P_ADDR: begin
            if (w_is_hex) begin
              w_addr   <= {w_addr[27:0], w_nibble};
              r_digits <= r_digits + 3'd1;
              if (r_digits == 3'd7) begin
                r_p_state <= P_SEP2;
              end
            end else if (r_rx_byte != c_us) begin
              err       <= 1'b1;
              r_p_state <= P_DISCARD;
            end
          end
          P_DATA: begin
            if (w_is_hex) begin
              w_data   <= {w_data[27:0], w_nibble};
              r_digits <= r_digits + 3'd1;
              if (r_digits == 3'd7) begin
                r_p_state <= P_WAIT_CR;
              end
            end else if (r_rx_byte != c_us) begin
              err       <= 1'b1;
              r_p_state <= P_DISCARD;
            end
          end
          P_WAIT_CR: begin
            if (r_rx_byte == c_cr) begin
              if (full) begin
                err <= 1'b1;
              end else begin
                w_req <= 1'b1;
              end
              r_p_state <= P_IDLE;
            end else if (r_rx_byte != c_lf && r_rx_byte != c_us) begin
              err       <= 1'b1;
              r_p_state <= P_DISCARD;
            end
          end
          P_DISCARD: begin
            if (r_rx_byte == c_cr) begin
              r_p_state <= P_IDLE;
            end
          end
          default: r_p_state <= P_IDLE;
        endcase
      end
    end
  end

`ifdef UART_DEBUG_PARSER_ECHO_EN
  logic w_tx_busy;

  // bytes arriving while a previous echo is still shifting out are not echoed
  uart_tx #(
    .DIV(c_div)
  ) u_echo_tx (
    .clk   (clk),
    .anrst (anrst),
    .start (r_byte_valid & ~w_tx_busy),
    .data  (r_rx_byte),
    .txd   (uart_txd),
    .busy  (w_tx_busy)
  );
`else
  assign uart_txd = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_debug_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_debug_parser
// Brief    : Randomized scoreboard bench for uart_debug_parser with a
//            string-level command grammar model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_debug_parser;
  localparam int CLK_HZ = 100;
  localparam int BAUD   = 10;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] SP = 8'h20;
  localparam logic [7:0] US = 8'h5F;

  logic        clk = 1'b0;
  logic        anrst = 1'b0;
  logic        uart_rxd = 1'b1;
  logic        full = 1'b0;
  logic        uart_txd;
  logic        w_req;
  logic        w_rnw;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic        err;

  uart_debug_parser #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) dut (
    .clk     (clk),
    .anrst   (anrst),
    .uart_rxd(uart_rxd),
    .uart_txd(uart_txd),
    .full    (full),
    .w_req   (w_req),
    .w_rnw   (w_rnw),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    bit          rnw;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] cmd_buf[$];
  bit         discarding = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;
`ifdef UART_DEBUG_PARSER_ECHO_EN
  logic [7:0] echo_q[$];
`else
  bit         txd_low = 1'b0;
`endif

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic bit is_hex(logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
           (c >= 8'h61 && c <= 8'h66);
  endfunction

  function automatic logic [3:0] hex_val(logic [7:0] c);
    if (c <= 8'h39) return 4'(c - 8'h30);
    if (c <= 8'h46) return 4'(c - 8'h41 + 8'd10);
    return 4'(c - 8'h61 + 8'd10);
  endfunction

  // Hex digits in a command prefix, or -1 once it can no longer be a command.
  function automatic int scan(logic [7:0] s[$]);
    int nd = 0;
    bit sp2 = 1'b0;
    logic [7:0] c;
    if (s.size() == 0) return 0;
    if (!(s[0] inside {8'h52, 8'h72, 8'h57, 8'h77})) return -1;
    if (s.size() > 1 && s[1] != SP) return -1;
    for (int i = 2; i < s.size(); i++) begin
      c = s[i];
      if (nd == 8 && !sp2) begin
        if (c != SP) return -1;
        sp2 = 1'b1;
      end else if (nd == 16) begin
        if (c != LF && c != US) return -1;
      end else if (is_hex(c)) begin
        nd++;
      end else if (c != US) begin
        return -1;
      end
    end
    return nd;
  endfunction

  function automatic logic [63:0] digits(logic [7:0] s[$]);
    logic [63:0] v = '0;
    for (int i = 2; i < s.size(); i++)
      if (is_hex(s[i])) v = {v[59:0], hex_val(s[i])};
    return v;
  endfunction

  function automatic void push_err();
    exp_t e;
    e = '{1'b1, 1'b0, 32'h0, 32'h0};
    exp_q.push_back(e);
    discarding = 1'b1;
    cmd_buf.delete();
  endfunction

  function automatic void model_byte(logic [7:0] b, bit stop_ok);
    exp_t e;
    if (!stop_ok) begin
      push_err();
      return;
    end
`ifdef UART_DEBUG_PARSER_ECHO_EN
    echo_q.push_back(b);
`endif
    if (discarding) begin
      if (b == CR) discarding = 1'b0;
      return;
    end
    if (cmd_buf.size() == 0 && (b == CR || b == LF || b == SP)) return;
    if (b == CR && scan(cmd_buf) == 16) begin
      if (full) begin
        push_err();
        discarding = 1'b0;
      end else begin
        e.is_err = 1'b0;
        e.rnw = (cmd_buf[0] == 8'h52) || (cmd_buf[0] == 8'h72);
        {e.addr, e.data} = digits(cmd_buf);
        exp_q.push_back(e);
        cmd_buf.delete();
      end
      return;
    end
    cmd_buf.push_back(b);
    if (scan(cmd_buf) < 0) push_err();
  endfunction

  task automatic send_byte(logic [7:0] b, bit stop_ok);
    model_byte(b, stop_ok);
    uart_rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rxd = stop_ok;
    repeat (DIV) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_str(string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic send_line(string s);
    send_str(s);
    send_byte(CR, 1'b1);
  endtask

  function automatic logic [7:0] hex_char(int n);
    if (n < 10) return 8'h30 + 8'(n);
    return ($urandom_range(0, 1) ? 8'h41 : 8'h61) + 8'(n - 10);
  endfunction

  task automatic send_random_cmd();
    logic [7:0] q[$];
    int bad_idx = -1;
    repeat ($urandom_range(0, 2)) q.push_back($urandom_range(0, 1) ? SP : LF);
    case ($urandom_range(0, 3))
      0:       q.push_back(8'h52);
      1:       q.push_back(8'h72);
      2:       q.push_back(8'h57);
      default: q.push_back(8'h77);
    endcase
    for (int w = 0; w < 2; w++) begin
      q.push_back(SP);
      for (int d = 0; d < 8; d++) begin
        if ($urandom_range(0, 3) == 0) q.push_back(US);
        q.push_back(hex_char($urandom_range(0, 15)));
      end
    end
    if ($urandom_range(0, 2) == 0) q.push_back($urandom_range(0, 1) ? LF : US);
    q.push_back(CR);
    if ($urandom_range(0, 4) == 0) q[$urandom_range(0, q.size() - 2)] = 8'($urandom_range(0, 255));
    if ($urandom_range(0, 5) == 0) bad_idx = $urandom_range(0, q.size() - 1);
    full = ($urandom_range(0, 4) == 0);
    for (int i = 0; i < q.size(); i++) send_byte(q[i], i != bad_idx);
    full = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (anrst === 1'b1 && (w_req === 1'b1 || err === 1'b1)) begin
      chk("req_err_exclusive", {31'b0, w_req & err}, 32'd0);
      chk("expected_event_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("event_is_err", {31'b0, err}, {31'b0, mon_e.is_err});
        if (!mon_e.is_err) begin
          chk("w_rnw", {31'b0, w_rnw}, {31'b0, mon_e.rnw});
          chk("w_addr", w_addr, mon_e.addr);
          chk("w_data", w_data, mon_e.data);
        end
      end
    end
  end

`ifdef UART_DEBUG_PARSER_ECHO_EN
  initial begin
    logic [7:0] rb;
    forever begin
      @(negedge uart_txd);
      repeat (DIV / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        rb[i] = uart_txd;
      end
      chk("echo_pending", 32'(echo_q.size() > 0), 32'd1);
      if (echo_q.size() > 0) chk("echo_byte", {24'b0, rb}, {24'b0, echo_q.pop_front()});
      repeat (DIV) @(negedge clk);
    end
  end
`else
  always @(negedge clk) begin
    if (anrst === 1'b1 && uart_txd !== 1'b1) txd_low = 1'b1;
  end
`endif

  initial begin
    repeat (5) @(negedge clk);
    chk("rst_w_req", {31'b0, w_req}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_w_rnw", {31'b0, w_rnw}, 32'd0);
    chk("rst_w_addr", w_addr, 32'd0);
    chk("rst_w_data", w_data, 32'd0);
    chk("rst_uart_txd", {31'b0, uart_txd}, 32'd1);
    anrst = 1'b1;
    repeat (3 * DIV) @(negedge clk);

    send_line("W 1234_5678 9ABC_DEF0");
    send_line("r 0000_00ff 00000000\n");
    send_line("W 12G4");
    send_line("R 00000001 00000002");
    full = 1'b1;
    send_line("W 00000010 00000020");
    full = 1'b0;
    send_line("W 00000010 00000020");
    send_str("W 12");
    send_byte("3", 1'b0);
    send_line("4 00000000");
    send_line("w 0000000A 0000000b");

    for (int n = 0; n < 16; n++) send_random_cmd();
    send_byte(CR, 1'b1);
    send_byte(CR, 1'b1);
    repeat (12 * DIV) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    // reset in the middle of a command and of a frame
    send_str("R DEAD");
    repeat (12 * DIV) @(negedge clk);
    uart_rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    anrst = 1'b0;
    uart_rxd = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_w_addr", w_addr, 32'd0);
    chk("midrst_w_rnw", {31'b0, w_rnw}, 32'd0);
    chk("midrst_uart_txd", {31'b0, uart_txd}, 32'd1);
    cmd_buf.delete();
    discarding = 1'b0;
    anrst = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    send_line("R 00000003 00000004");
    repeat (12 * DIV) @(negedge clk);
    chk("final_drained", exp_q.size(), 32'd0);
`ifdef UART_DEBUG_PARSER_ECHO_EN
    chk("echo_drained", echo_q.size(), 32'd0);
`else
    chk("txd_idle_high", {31'b0, txd_low}, 32'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
